// File: rtl/ram_pkg.sv
// Shared types and defaults for the parametrised synchronous RAM.
// Imported by the interface, the clear sequencer and the top.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;

  // Fill bit replicated across the word during a clear sweep.
  localparam logic CLEAR_WORD = 1'b0;

endpackage

// File: rtl/ram_sync_param_if.sv
// Bus bundle between the CPU datapath and the RAM.
// Active-low select, read/write-bar, clear request and status.
interface ram_sync_param_if
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              csn;
  logic              rwn;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] datain;
  logic              clr;
  logic              ready;
  logic              busy;
  logic              rvalid;

  modport master (
    output csn, rwn, addr, datain, clr,
    input  ready, busy, rvalid
  );

  modport slave (
    input  csn, rwn, addr, datain, clr,
    output ready, busy, rvalid
  );

endinterface

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps zeros through every word after
// reset or on request, then idles and grants bus access.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  assign clr_addr = ptr_q;

  // Next state, pointer advance and status outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    busy    = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // State and pointer registers; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_sync_param.sv
// Single-port synchronous RAM with registered read, valid
// strobe and a hardware clear sweep owning the write port.
module ram_sync_param
  import ram_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter bit TRISTATE_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  ram_sync_param_if.slave   bus,
  output wire  [DATA_W-1:0] dataout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;
  logic              ready;

  logic              acc;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy),
    .ready    (ready)
  );

  // Write-port mux and read-register next values; the
  // sweep and bus accesses never overlap since ready=0.
  always_comb begin
    acc      = ~rst & ~bus.csn & ready;
    rd_en    = acc & bus.rwn;
    wr_en    = ~rst & (clr_we | (acc & ~bus.rwn));
    wr_addr  = clr_we ? clr_addr : bus.addr;
    wr_data  = clr_we ? {DATA_W{CLEAR_WORD}} : bus.datain;
    rdata_d  = rd_en ? mem_q[bus.addr] : rdata_q;
    rvalid_d = rd_en;
  end

  // Storage array; contents come defined from the sweep.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read data register and its one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.ready  = ready;
  assign bus.busy   = busy;
  assign bus.rvalid = rvalid_q;

  assign dataout = (TRISTATE_OUT && !rvalid_q)
                 ? {DATA_W{1'bz}} : rdata_q;

endmodule

// File: tb/tb_ram_sync_param.sv
// Randomised and directed bench for ram_sync_param with a
// behavioural array model; second instance covers tri-state.
module tb_ram_sync_param;

  logic clk;
  logic rst;
  logic rst8;
  wire [3:0] dout4;
  wire [7:0] dout8;

  int n_chk;
  int n_fail;

  ram_sync_param_if #(.DATA_W(4), .ADDR_W(4)) bus4 ();
  ram_sync_param_if #(.DATA_W(8), .ADDR_W(6)) bus8 ();

  ram_sync_param dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus4),
    .dataout (dout4)
  );

  ram_sync_param #(
    .DATA_W       (8),
    .ADDR_W       (6),
    .TRISTATE_OUT (1'b1)
  ) dut8 (
    .clk     (clk),
    .rst     (rst8),
    .bus     (bus8),
    .dataout (dout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Behavioural model: words, remaining sweep cycles,
  // last read word and whether a read was accepted.
  logic [3:0] m_mem [16];
  int         m_left;
  logic       m_rv;
  logic [3:0] m_dout;
  bit         chk_en;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 16;
      m_rv   = 1'b0;
      m_dout = 4'h0;
      foreach (m_mem[i]) m_mem[i] = 4'h0;
      chk_en = 1'b1;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_rv   = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (!bus4.csn) begin
        if (bus4.rwn) begin
          m_dout = m_mem[bus4.addr];
          m_rv   = 1'b1;
        end else begin
          m_mem[bus4.addr] = bus4.datain;
        end
      end
      if (bus4.clr) begin
        m_left = 16;
        foreach (m_mem[i]) m_mem[i] = 4'h0;
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(bus4.ready), 32'(m_left == 0));
      check("busy", 32'(bus4.busy), 32'(m_left != 0));
      check("rvalid", 32'(bus4.rvalid), 32'(m_rv));
      check("dataout", 32'(dout4), 32'(m_dout));
    end
  end

  task automatic drv(input logic c, input logic r,
                     input logic [3:0] a,
                     input logic [3:0] d,
                     input logic cl);
    bus4.csn    = c;
    bus4.rwn    = r;
    bus4.addr   = a;
    bus4.datain = d;
    bus4.clr    = cl;
    @(negedge clk);
  endtask

  task automatic drv8(input logic c, input logic r,
                      input logic [5:0] a,
                      input logic [7:0] d,
                      input logic cl);
    bus8.csn    = c;
    bus8.rwn    = r;
    bus8.addr   = a;
    bus8.datain = d;
    bus8.clr    = cl;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    rst8   = 1'b1;
    bus8.csn = 1'b1;
    bus8.rwn = 1'b1;
    bus8.addr = '0;
    bus8.datain = '0;
    bus8.clr = 1'b0;
    drv(1, 1, 0, 0, 0);
    rst  = 1'b0;
    rst8 = 1'b0;

    // Reset sweep length.
    check("rst_busy", 32'(bus4.busy), 1);
    check("rst_ready", 32'(bus4.ready), 0);
    n = 0;
    while (bus4.busy && n < 200) begin
      n++;
      drv(1, 1, 0, 0, 0);
    end
    check("rst_sweep_len", n, 16);

    // Every word reads back zero.
    for (int a = 0; a < 16; a++) begin
      drv(0, 1, 4'(a), 0, 0);
      check("zero_rv", 32'(bus4.rvalid), 1);
      check("zero_data", 32'(dout4), 0);
    end

    // Write then immediate read-back.
    drv(0, 0, 3, 4'hA, 0);
    drv(0, 1, 3, 0, 0);
    check("wr_rd_rv", 32'(bus4.rvalid), 1);
    check("wr_rd_data", 32'(dout4), 32'hA);
    drv(1, 1, 0, 0, 0);
    check("rv_one_cycle", 32'(bus4.rvalid), 0);
    drv(0, 1, 4, 0, 0);
    check("rd4_data", 32'(dout4), 0);

    // Back-to-back reads.
    for (int a = 1; a < 16; a++) drv(0, 0, 4'(a), 4'(a), 0);
    for (int a = 1; a < 16; a++) begin
      drv(0, 1, 4'(a), 0, 0);
      check("b2b_rv", 32'(bus4.rvalid), 1);
      check("b2b_data", 32'(dout4), a);
    end

    // Clear request with reads held during the sweep;
    // a second clr mid-sweep must not restart it.
    for (int a = 0; a < 16; a++) drv(0, 0, 4'(a), 4'h5, 0);
    drv(0, 1, 7, 0, 1);
    check("clr_rd_rv", 32'(bus4.rvalid), 1);
    check("clr_rd_data", 32'(dout4), 5);
    check("clr_busy", 32'(bus4.busy), 1);
    n = 0;
    while (!bus4.ready && n < 200) begin
      n++;
      drv(0, 1, 4'(n), 0, n == 3);
    end
    check("clr_sweep_len", n, 16);
    for (int a = 0; a < 16; a++) begin
      drv(0, 1, 4'(a), 0, 0);
      check("clr_zero", 32'(dout4), 0);
    end

    // Reset mid-sweep restarts from the beginning.
    drv(1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) drv(1, 1, 0, 0, 0);
    rst = 1'b1;
    drv(1, 1, 0, 0, 0);
    rst = 1'b0;
    n = 0;
    while (bus4.busy && n < 200) begin
      n++;
      drv(1, 1, 0, 0, 0);
    end
    check("rst_mid_len", n, 16);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drv($urandom_range(0, 9) < 3,
          1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)),
          $urandom_range(0, 59) == 0);
    end
    rst = 1'b0;
    drv(1, 1, 0, 0, 0);

    // Wide instance with tri-state output.
    rst8 = 1'b1;
    drv8(1, 1, 0, 0, 0);
    rst8 = 1'b0;
    check("w_rst_z", 32'(dout8 === 8'hzz), 1);
    n = 0;
    while (bus8.busy && n < 500) begin
      n++;
      drv8(1, 1, 0, 0, 0);
    end
    check("w_sweep_len", n, 64);
    check("w_idle_z", 32'(dout8 === 8'hzz), 1);
    drv8(0, 0, 63, 8'hC3, 0);
    drv8(0, 1, 63, 0, 0);
    check("w_rv", 32'(bus8.rvalid), 1);
    check("w_data", 32'(dout8), 32'hC3);
    drv8(1, 1, 0, 0, 0);
    check("w_after_z", 32'(dout8 === 8'hzz), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
